vga_scanout: RTL

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout.sv | 110 +++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - 640x480@60 VGA timing generator and registered pixel scanout
// Optional VGA_CLK_DIV_EN: clk is 2x the pixel rate and an internal toggle supplies pix_en.
module vga_scanout (
    input  logic        clk,
    input  logic        rst_n,
    output logic [9:0]  x,
    output logic [9:0]  y,
    input  logic [23:0] in_color,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        frame_tick
);

    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_ACTIVE     = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] V_LAST       = 10'd524;

    logic       pix_en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       h_last;
    logic       v_last;
    logic       active;
    logic       hs_zone;
    logic       vs_zone;

`ifdef VGA_CLK_DIV_EN
    logic div_tgl;

    // Toggle starts at 0, so the first pixel cycle lands on the 2nd clk after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_tgl <= 1'b0;
        end else begin
            div_tgl <= ~div_tgl;
        end
    end

    assign pix_en = div_tgl;
`else
    assign pix_en = 1'b1;
`endif

    assign x = h_cnt;
    assign y = v_cnt;

    assign h_last  = (h_cnt == H_LAST);
    assign v_last  = (v_cnt == V_LAST);
    assign active  = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
    assign hs_zone = (h_cnt >= H_SYNC_START) && (h_cnt <= H_SYNC_END);
    assign vs_zone = (v_cnt >= V_SYNC_START) && (v_cnt <= V_SYNC_END);

    always_comb begin
        h_nxt = h_last ? 10'd0 : h_cnt + 10'd1;
        v_nxt = v_cnt;
        if (h_last) begin
            v_nxt = v_last ? 10'd0 : v_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (pix_en) begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // Outputs describe the position sampled on the previous pixel cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r       <= 8'd0;
            vga_g       <= 8'd0;
            vga_b       <= 8'd0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else if (pix_en) begin
            vga_r       <= active ? in_color[23:16] : 8'd0;
            vga_g       <= active ? in_color[15:8]  : 8'd0;
            vga_b       <= active ? in_color[7:0]   : 8'd0;
            vga_hs      <= ~hs_zone;
            vga_vs      <= ~vs_zone;
            vga_blank_n <= active;
        end
    end

    // Evaluated every clk so the pulse is one clk wide even when pix_en is divided.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= pix_en && h_last && (v_cnt == V_ACTIVE - 10'd1);
        end
    end

endmodule
